// File: rtl/time_mode_sequencer.sv
// rtl/time_mode_sequencer.sv - selects one of NCH time-field channels with button advance and inactivity return
//
// Ports:
//   clk      in   system clock, all state updates on rising edge
//   rst      in   synchronous active-high reset
//   ch_data  in   NCH*W packed channels, channel k at [k*W +: W]
//   adv      in   debounced mode-button level, each rising edge advances sel
//   lock     in   freezes sel and inactivity timer while high
//   sel      out  currently selected channel index
//   out      out  registered copy of the selected channel
//   chg      out  one-cycle pulse after any edge on which sel changed
//   blink    out  display blink enable (only with TIME_MODE_BLINK_EN, else 0)
//
// Optional feature macro: TIME_MODE_BLINK_EN
module time_mode_sequencer #(
    parameter int NCH        = 3,
    parameter int W          = 3,
    parameter int SELW       = 2,
    parameter int TIMEOUT    = 16,
    parameter int BLINK_HALF = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH*W-1:0] ch_data,
    input  logic             adv,
    input  logic             lock,
    output logic [SELW-1:0]  sel,
    output logic [W-1:0]     out,
    output logic             chg,
    output logic             blink
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [SELW-1:0] SEL_LAST  = SELW'(NCH - 1);
    localparam logic [TW-1:0]   TIMER_END = TW'(TIMEOUT - 1);

    logic            adv_q;
    logic            adv_rise;
    logic [SELW-1:0] sel_nxt;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_nxt;
    logic [W-1:0]    sel_data;

    assign adv_rise = adv & ~adv_q;

    always_comb begin
        sel_nxt   = sel;
        timer_nxt = timer;
        if (sel > SEL_LAST) begin
            // Unreachable encodings recover to the normal display.
            sel_nxt   = '0;
            timer_nxt = '0;
        end else if (lock) begin
            sel_nxt   = sel;
            timer_nxt = timer;
        end else if (adv_rise) begin
            sel_nxt   = (sel == SEL_LAST) ? '0 : sel + 1'b1;
            timer_nxt = '0;
        end else if (sel == '0) begin
            timer_nxt = '0;
        end else if (timer == TIMER_END) begin
            sel_nxt   = '0;
            timer_nxt = '0;
        end else begin
            timer_nxt = timer + 1'b1;
        end
    end

    // Mux on the registered sel, so out lags a sel change by one edge.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) begin
                sel_data = ch_data[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adv_q <= 1'b0;
            sel   <= '0;
            timer <= '0;
            chg   <= 1'b0;
            out   <= '0;
        end else begin
            // adv_q tracks adv even while locked so a press made during
            // lock is not replayed when lock drops.
            adv_q <= adv;
            sel   <= sel_nxt;
            timer <= timer_nxt;
            chg   <= (sel_nxt != sel);
            out   <= sel_data;
        end
    end

`ifdef TIME_MODE_BLINK_EN
    localparam int BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_END = BW'(BLINK_HALF - 1);

    logic [BW-1:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (sel_nxt != sel) begin
            // Every selection change restarts the phase with blink on.
            blink_cnt <= '0;
            blink     <= (sel_nxt != '0);
        end else if (sel == '0 || lock) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == BLINK_END) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_time_mode_sequencer.sv
// tb/tb_time_mode_sequencer.sv - scoreboard bench for time_mode_sequencer
module tb_time_mode_sequencer;

    localparam int NCH = 3;
    localparam int W   = 3;
    localparam int SELW = 2;

    localparam int K_SEL   = 0;
    localparam int K_OUT   = 1;
    localparam int K_CHG   = 2;
    localparam int K_BLINK = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH*W-1:0] ch_data;
    logic             adv;
    logic             lock;
    logic [SELW-1:0]  sel;
    logic [W-1:0]     out;
    logic             chg;
    logic             blink;

    int checks = 0;
    int errors = 0;

    int    q_kind[$];
    int    q_val[$];
    string q_tag[$];

    time_mode_sequencer #(
        .NCH(NCH), .W(W), .SELW(SELW), .TIMEOUT(16), .BLINK_HALF(4)
    ) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .adv(adv), .lock(lock),
        .sel(sel), .out(out), .chg(chg), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic push(input int kind, input int val, input string tag);
        q_kind.push_back(kind);
        q_val.push_back(val);
        q_tag.push_back(tag);
    endtask

    task automatic drain();
        int          kind;
        int          val;
        string       tag;
        logic [31:0] obs;
        while (q_kind.size() > 0) begin
            kind = q_kind.pop_front();
            val  = q_val.pop_front();
            tag  = q_tag.pop_front();
            case (kind)
                K_SEL:   obs = {30'd0, sel};
                K_OUT:   obs = {29'd0, out};
                K_CHG:   obs = {31'd0, chg};
                default: obs = {31'd0, blink};
            endcase
            checks++;
            assert (obs === val) else begin
                errors++;
                $error("FAIL %s observed %0d expected %0d", tag, obs, val);
            end
        end
`ifndef TIME_MODE_BLINK_EN
        checks++;
        assert (blink === 1'b0) else begin
            errors++;
            $error("FAIL blink_off observed %0d expected 0", blink);
        end
`endif
    endtask

    // Advance one edge and compare everything queued for it.
    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    // One press: 2 cycles high, 3 low.
    task automatic press(input int new_sel, input int old_out, input int new_out);
        adv = 1'b1;
        push(K_SEL, new_sel, "press_sel");
        push(K_CHG, 1, "press_chg");
        push(K_OUT, old_out, "press_out_old");
        step();
        push(K_SEL, new_sel, "press_sel_hold");
        push(K_CHG, 0, "press_chg_once");
        push(K_OUT, new_out, "press_out_new");
        step();
        adv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(K_SEL, new_sel, "press_sel_idle");
            push(K_CHG, 0, "press_chg_idle");
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        adv = 1'b1;
        lock = 1'b0;
        ch_data = {3'd5, 3'd2, 3'd6};

        // Reset with the button held
        for (int i = 0; i < 2; i++) begin
            push(K_SEL, 0, "rst_sel");
            push(K_OUT, 0, "rst_out");
            push(K_CHG, 0, "rst_chg");
            step();
        end
        rst = 1'b0;
        push(K_SEL, 1, "post_rst_adv_sel");
        push(K_OUT, 6, "post_rst_out");
        push(K_CHG, 1, "post_rst_chg");
        step();
        push(K_SEL, 1, "held_adv_once");
        push(K_OUT, 2, "held_out");
        push(K_CHG, 0, "held_chg");
        step();
        adv = 1'b0;

        rst = 1'b1;
        push(K_SEL, 0, "rst2_sel");
        push(K_CHG, 0, "rst2_chg");
        step();
        rst = 1'b0;

        // Advance and wrap
        press(1, 6, 2);
        press(2, 2, 5);
        press(0, 5, 6);

        // Timeout 16 cycles after the advance edge
        adv = 1'b1;
        push(K_SEL, 1, "to_adv");
        push(K_CHG, 1, "to_adv_chg");
        step();
        adv = 1'b0;
        for (int i = 1; i < 16; i++) begin
            push(K_SEL, 1, "to_wait");
            push(K_CHG, 0, "to_wait_chg");
            step();
        end
        push(K_SEL, 0, "to_return");
        push(K_CHG, 1, "to_return_chg");
        push(K_OUT, 2, "to_out_lag");
        step();
        push(K_SEL, 0, "to_idle");
        push(K_CHG, 0, "to_idle_chg");
        push(K_OUT, 6, "to_out_ch0");
        step();

        // Press at cycle 15 restarts the timer
        adv = 1'b1;
        push(K_SEL, 1, "p15_first");
        step();
        adv = 1'b0;
        for (int i = 1; i < 15; i++) begin
            push(K_SEL, 1, "p15_wait");
            step();
        end
        adv = 1'b1;
        push(K_SEL, 2, "p15_second");
        push(K_CHG, 1, "p15_chg");
        step();
        adv = 1'b0;
        for (int i = 1; i < 16; i++) begin
            push(K_SEL, 2, "p15_restart_wait");
            push(K_CHG, 0, "p15_restart_chg");
            step();
        end
        push(K_SEL, 0, "p15_timeout");
        push(K_CHG, 1, "p15_timeout_chg");
        step();

        // Lock freezes selection and timer, ignores presses
        adv = 1'b1;
        push(K_SEL, 1, "lk_adv");
        step();
        adv = 1'b0;
        lock = 1'b1;
        for (int i = 0; i < 40; i++) begin
            adv = (i == 5 || i == 6 || i == 20 || i == 21);
            push(K_SEL, 1, "lk_sel");
            push(K_CHG, 0, "lk_chg");
            push(K_OUT, 2, "lk_out");
            step();
        end
        adv = 1'b0;
        lock = 1'b0;
        for (int i = 1; i < 16; i++) begin
            push(K_SEL, 1, "lk_release_wait");
            push(K_CHG, 0, "lk_release_chg");
            step();
        end
        push(K_SEL, 0, "lk_timeout");
        push(K_CHG, 1, "lk_timeout_chg");
        step();

        // Data tracking on channel 2
        press(1, 6, 2);
        press(2, 2, 5);
        ch_data[8:6] = 3'd3;
        push(K_SEL, 2, "dt_sel");
        push(K_OUT, 3, "dt_out_new");
        step();
        ch_data[2:0] = 3'd1;
        ch_data[5:3] = 3'd7;
        push(K_OUT, 3, "dt_out_other");
        step();

`ifdef TIME_MODE_BLINK_EN
        rst = 1'b1;
        push(K_BLINK, 0, "bl_rst");
        step();
        rst = 1'b0;
        adv = 1'b1;
        push(K_SEL, 1, "bl_sel");
        push(K_BLINK, 1, "bl_start");
        step();
        adv = 1'b0;
        for (int i = 1; i < 12; i++) begin
            push(K_BLINK, ((i / 4) % 2 == 0) ? 1 : 0, "bl_pattern");
            step();
        end
        adv = 1'b1;
        push(K_SEL, 2, "bl_sel2");
        push(K_BLINK, 1, "bl_restart");
        step();
        adv = 1'b0;
        step();
        adv = 1'b1;
        push(K_SEL, 0, "bl_sel0");
        push(K_BLINK, 0, "bl_off");
        step();
        adv = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_mode_sequencer.md
Name: time_mode_sequencer

Overview:
Parametrised successor to the clock's fixed two-source time-mode selector. Selects one of NCH time-field channels, each W bits wide, and presents it on a registered output. A debounced mode-button level advances the selection once per press. An inactivity timer returns the selection to channel 0 (normal display). It sits between the time-field counters (hours/minutes/weekday etc.) and the display/setting logic of the digital clock.

Parameters:
NCH, 3, number of selectable channels (2..8)
W, 3, width of each channel field in bits
SELW, 2, width of sel output; must satisfy 2**SELW >= NCH
TIMEOUT, 16, inactivity cycles before auto-return to channel 0 (>=2)
BLINK_HALF, 4, half-period in cycles of blink output (used only with the optional feature)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
ch_data  input  NCH*W  packed channels; channel k occupies bits [k*W+W-1 : k*W]
adv  input  1  debounced mode-button level; each rising edge advances the selection
lock  input  1  when 1, freezes selection and timer (setting in progress)
sel  output  SELW  currently selected channel index
out  output  W  registered copy of the selected channel
chg  output  1  one-cycle pulse when sel changes
blink  output  1  display blink enable (optional feature)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: sel=0, out=0, chg=0, blink=0, internal adv_q=0, timer=0, blink counter=0.
- Edge detect: adv_rise = adv & ~adv_q; adv_q <= adv every cycle, including while lock=1. A held button produces exactly one advance.
- Advance: if adv_rise & ~lock, then sel <= (sel==NCH-1) ? 0 : sel+1 (wrap), and timer <= 0.
- Timer: counts only while sel!=0 and lock=0 and no adv_rise. When timer==TIMEOUT-1, the next edge sets sel<=0 and timer<=0. While sel==0, timer is held at 0.
- Priority: rst > lock (freezes sel/timer) > adv_rise > timeout > count.
- chg: registered; equals 1 in the cycle after any edge on which sel changed value, 0 otherwise. An NCH=1-like wrap to the same value does not pulse.
- out: out <= ch_data slice indexed by the current sel, every cycle regardless of lock. Latency is 1 cycle from a ch_data change. After sel changes at edge n, out shows the new channel after edge n+1.
- sel values >= NCH are unreachable. If reached, the next edge forces sel to 0.
- Reset mid-sequence: sel returns to 0 immediately at that edge. If adv is high during reset, adv_q is cleared, so a still-held button generates one advance after rst deasserts.

Optional Feature:
Macro TIME_MODE_BLINK_EN.
- With the macro defined: while sel!=0 and lock=0, blink toggles every BLINK_HALF cycles. The blink counter resets on every sel change, and blink restarts at 1 on the first cycle after the change. While sel==0 or lock=1, blink=0 and the counter is held at 0.
- Without the macro: blink is tied to 0 and no blink counter exists.

Test Plan:
- Reset/defaults: rst=1 for 2 cycles with ch_data={3'd5,3'd2,3'd6}, adv=1 -> sel=0, out=0, chg=0. One cycle after rst drops -> out=6. adv still high -> one advance, sel=1.
- Advance and wrap (NCH=3): three separate adv pulses, each 2 cycles high and 3 low -> sel goes 0→1→2→0, chg pulses exactly 3 times, out follows 6→2→5→6 each one cycle after sel.
- Timeout (TIMEOUT=16): one press to sel=1, then idle -> sel returns to 0 exactly 16 cycles after the advance edge, with a chg pulse. A press at cycle 15 instead keeps sel=2 and restarts the timer.
- Lock: sel=1, lock=1 for 40 cycles with 2 adv pulses -> sel stays 1, no chg, no timeout. Release lock -> timeout after 16 further idle cycles.
- Data tracking: sel=2, change channel 2 from 5 to 3 -> out=3 one cycle later; changes on other channels do not affect out.
- TIME_MODE_BLINK_EN (BLINK_HALF=4): sel=1 -> blink pattern 1111 0000 1111…; sel back to 0 -> blink=0. Without the macro, blink=0 throughout all the above scenarios.
